// File: rtl/operand_fetch.sv
// Issue stage between decode and execute: reads both source operands from the
// register file, snoops writeback so operands never go stale, and hands them to execute.
module operand_fetch #(
  parameter int XLEN         = 32,
  parameter int ADDR_BITS    = 4,
  parameter int PAYLOAD_BITS = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_BITS-1:0]    in_rs1,
  input  logic [ADDR_BITS-1:0]    in_rs2,
  input  logic [PAYLOAD_BITS-1:0] in_payload,
  output logic                    rf_read_en_n,
  output logic [ADDR_BITS-1:0]    rf_read_addr_a,
  output logic [ADDR_BITS-1:0]    rf_read_addr_b,
  input  logic [XLEN-1:0]         rf_read_data_a,
  input  logic [XLEN-1:0]         rf_read_data_b,
  input  logic                    wb_valid,
  input  logic [ADDR_BITS-1:0]    wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic [PAYLOAD_BITS-1:0] out_payload
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_e;

  state_e                  state_q;
  logic [ADDR_BITS-1:0]    rs1_q, rs2_q;
  logic [PAYLOAD_BITS-1:0] payload_q;
  logic                    bypHit1_q, bypHit2_q;
  logic [XLEN-1:0]         bypData1_q, bypData2_q;
  logic [XLEN-1:0]         op1_q, op2_q, op1_d, op2_d;
  logic                    outValid_q;

  logic inReady, accept;
  logic acceptHit1, acceptHit2;
  logic wbHit1, wbHit2;

  assign inReady = (state_q == IDLE) | ((state_q == VALID) & out_ready);
  assign accept  = in_valid & inReady & ~reset;

  assign in_ready       = inReady;
  assign rf_read_en_n   = ~accept;
  assign rf_read_addr_a = in_rs1;
  assign rf_read_addr_b = in_rs2;

  // The register file returns the pre-write value when a write lands on the accept
  // edge, so that write is remembered here and replayed during FETCH.
  assign acceptHit1 = wb_valid & (wb_addr == in_rs1) & (in_rs1 != '0);
  assign acceptHit2 = wb_valid & (wb_addr == in_rs2) & (in_rs2 != '0);

  assign wbHit1 = wb_valid & (wb_addr == rs1_q) & (rs1_q != '0);
  assign wbHit2 = wb_valid & (wb_addr == rs2_q) & (rs2_q != '0);

  function automatic logic [XLEN-1:0] fetchOperand(
    input logic [ADDR_BITS-1:0] rs,
    input logic                 wbHit,
    input logic [XLEN-1:0]      wbData,
    input logic                 bypHit,
    input logic [XLEN-1:0]      bypData,
    input logic [XLEN-1:0]      rfData
  );
    if (rs == '0)  return '0;
    if (wbHit)     return wbData;
    if (bypHit)    return bypData;
    return rfData;
  endfunction

  // Operands load in FETCH and afterwards only follow writebacks to their register.
  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    unique case (state_q)
      FETCH: begin
        op1_d = fetchOperand(rs1_q, wbHit1, wb_data, bypHit1_q, bypData1_q, rf_read_data_a);
        op2_d = fetchOperand(rs2_q, wbHit2, wb_data, bypHit2_q, bypData2_q, rf_read_data_b);
      end
      VALID: begin
        if (wbHit1) op1_d = wb_data;
        if (wbHit2) op2_d = wb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      payload_q  <= '0;
      bypHit1_q  <= 1'b0;
      bypHit2_q  <= 1'b0;
      bypData1_q <= '0;
      bypData2_q <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      if (accept) begin
        rs1_q      <= in_rs1;
        rs2_q      <= in_rs2;
        payload_q  <= in_payload;
        bypHit1_q  <= acceptHit1;
        bypHit2_q  <= acceptHit2;
        bypData1_q <= wb_data;
        bypData2_q <= wb_data;
      end
      unique case (state_q)
        IDLE: begin
          outValid_q <= 1'b0;
          if (accept) state_q <= FETCH;
        end
        FETCH: begin
          state_q    <= VALID;
          outValid_q <= 1'b1;
        end
        VALID: begin
          if (out_ready) begin
            state_q    <= accept ? FETCH : IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = outValid_q;
  assign out_rs1_data = op1_q;
  assign out_rs2_data = op2_q;
  assign out_payload  = payload_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized scoreboard bench for operand_fetch: a register file model drives the read
// port, and every presented operand must equal the architectural register value.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int AB   = 4;
  localparam int PB   = 40;

  logic          clk, reset;
  logic          in_valid, in_ready;
  logic [AB-1:0] in_rs1, in_rs2;
  logic [PB-1:0] in_payload;
  logic          rf_read_en_n;
  logic [AB-1:0] rf_read_addr_a, rf_read_addr_b;
  logic [XLEN-1:0] rf_read_data_a, rf_read_data_b;
  logic          wb_valid;
  logic [AB-1:0] wb_addr;
  logic [XLEN-1:0] wb_data;
  logic          out_valid, out_ready;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data;
  logic [PB-1:0] out_payload;

  typedef struct packed {
    logic [AB-1:0] rs1;
    logic [AB-1:0] rs2;
    logic [PB-1:0] payload;
    logic [31:0]   acceptCycle;
  } txn_t;

  txn_t        expQ[$];
  logic [XLEN-1:0] archRegs [16];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] cycle = 0;

  operand_fetch #(.XLEN(XLEN), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_payload(in_payload),
    .rf_read_en_n(rf_read_en_n),
    .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_payload(out_payload)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Register file: registered read (pre-write value), r0 never written.
  always @(posedge clk) begin
    if (!rf_read_en_n) begin
      rf_read_data_a <= archRegs[rf_read_addr_a];
      rf_read_data_b <= archRegs[rf_read_addr_b];
    end
    if (wb_valid && wb_addr != 0) archRegs[wb_addr] <= wb_data;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Monitor: an instruction appears two cycles after acceptance and, while shown,
  // carries the current architectural value of each source register.
  always @(negedge clk) begin : monitor
    txn_t front;
    txn_t newTxn;
    logic expValid, expReady, acc;
    logic [XLEN-1:0] e1, e2;
    if (reset) begin
      checkOutput("reset_out_valid", 64'(out_valid), 64'(1'b0));
      checkOutput("reset_rf_read_en_n", 64'(rf_read_en_n), 64'(1'b1));
      expQ.delete();
    end else begin
      expValid = 1'b0;
      front    = '0;
      if (expQ.size() > 0) begin
        front    = expQ[0];
        expValid = (cycle >= front.acceptCycle + 2);
      end
      checkOutput("out_valid", 64'(out_valid), 64'(expValid));
      if (expValid) begin
        e1 = (front.rs1 == 0) ? '0 : archRegs[front.rs1];
        e2 = (front.rs2 == 0) ? '0 : archRegs[front.rs2];
        checkOutput("out_rs1_data", 64'(out_rs1_data), 64'(e1));
        checkOutput("out_rs2_data", 64'(out_rs2_data), 64'(e2));
        checkOutput("out_payload", 64'(out_payload), 64'(front.payload));
      end
      expReady = (expQ.size() == 0) || (expValid && out_ready);
      checkOutput("in_ready", 64'(in_ready), 64'(expReady));
      acc = in_valid && expReady;
      checkOutput("rf_read_en_n", 64'(rf_read_en_n), 64'(!acc));
      if (acc) begin
        checkOutput("rf_read_addr_a", 64'(rf_read_addr_a), 64'(in_rs1));
        checkOutput("rf_read_addr_b", 64'(rf_read_addr_b), 64'(in_rs2));
      end
      if (expValid && out_ready) void'(expQ.pop_front());
      if (acc) begin
        newTxn.rs1         = in_rs1;
        newTxn.rs2         = in_rs2;
        newTxn.payload     = in_payload;
        newTxn.acceptCycle = cycle;
        expQ.push_back(newTxn);
      end
    end
  end

  // Drives one cycle of inputs, then advances to just after the next rising edge.
  task automatic applyStimulus(input logic inV, input logic [AB-1:0] r1, input logic [AB-1:0] r2,
                               input logic [PB-1:0] pl, input logic wbV, input logic [AB-1:0] wbA,
                               input logic [XLEN-1:0] wbD, input logic oRdy);
    in_valid   = inV;
    in_rs1     = r1;
    in_rs2     = r2;
    in_payload = pl;
    wb_valid   = wbV;
    wb_addr    = wbA;
    wb_data    = wbD;
    out_ready  = oRdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) archRegs[i] = '0;
    rf_read_data_a = '0;
    rf_read_data_b = '0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_payload = '0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'(1'b1));

    // Basic read of r3/r5.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 32'h11, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 32'h22, 1'b1);
    applyStimulus(1'b1, 4'd3, 4'd5, 40'hA0_0000_0001, 1'b0, '0, '0, 1'b1);
    idle(3);

    // r0 operands while r0 write is attempted.
    applyStimulus(1'b1, 4'd0, 4'd0, 40'hA0_0000_0002, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1);
    idle(3);

    // Writeback to r7 on the accept cycle.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 32'h1, 1'b1);
    applyStimulus(1'b1, 4'd7, 4'd2, 40'hA0_0000_0003, 1'b1, 4'd7, 32'hDEAD_BEEF, 1'b1);
    idle(3);

    // Stall three cycles in VALID with a writeback to r5 on the second.
    applyStimulus(1'b1, 4'd3, 4'd5, 40'hA0_0000_0004, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 32'h55, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    idle(2);

    // Back-to-back issue.
    applyStimulus(1'b1, 4'd3, 4'd7, 40'hA0_0000_0005, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 4'd5, 4'd5, 40'hA0_0000_0006, 1'b0, '0, '0, 1'b1);
    idle(3);

    // Reset while in FETCH.
    applyStimulus(1'b1, 4'd4, 4'd6, 40'hA0_0000_0007, 1'b0, '0, '0, 1'b1);
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    checkOutput("fetch_reset_out_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("fetch_reset_rf_read_en_n", 64'(rf_read_en_n), 64'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("fetch_reset_release_in_ready", 64'(in_ready), 64'(1'b1));
    checkOutput("fetch_reset_release_out_valid", 64'(out_valid), 64'(1'b0));
    idle(2);

    // Reset while presenting in VALID.
    applyStimulus(1'b1, 4'd3, 4'd5, 40'hA0_0000_0008, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("valid_reset_out_valid", 64'(out_valid), 64'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Random traffic with dense register collisions and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [PB-1:0] pl;
      pl    = {8'($urandom()), 32'($urandom())};
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus(($urandom_range(0, 9) < 6),
                    4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), pl,
                    ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 7)), $urandom(),
                    ($urandom_range(0, 9) < 7));
      reset = 1'b0;
    end

    idle(6);
    checkOutput("final_out_valid", 64'(out_valid), 64'(1'b0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
